// File: rtl/product_accumulator_if.sv
// Handshake bundle between the 2-bit multiplier's product stream, the
// accumulator and the result consumer.
interface product_accumulator_if #(
   parameter int ACC_W = 8
);
   logic             start;
   logic             p3;
   logic             p2;
   logic             p1;
   logic             p0;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;
   logic             busy;

   modport master (
      output start, p3, p2, p1, p0, in_valid, out_ready,
      input  in_ready, acc_out, out_valid, overflow, busy
   );

   modport slave (
      input  start, p3, p2, p1, p0, in_valid, out_ready,
      output in_ready, acc_out, out_valid, overflow, busy
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums LEN consecutive 4-bit products into an ACC_W-bit result held behind a
// valid/ready handshake. Define ACC_SATURATE_EN to clamp instead of wrap on overflow.
module product_accumulator #(
   parameter int ACC_W = 8,
   parameter int LEN   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   product_accumulator_if.slave    bus
);
   localparam int CNT_W = $clog2(LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;

   logic [3:0]         prod_s;
   logic [ACC_W:0]     sum_s;
   logic               beat_s;
   logic               last_s;

   assign prod_s = {bus.p3, bus.p2, bus.p1, bus.p0};
   assign beat_s = (state_q == S_ACC) && bus.in_valid;
   assign sum_s  = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, prod_s};
   assign last_s = (count_q == CNT_W'(LEN - 1));

   // Next-state logic; acc/count/overflow only move on start or an accepted beat.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_ACC;
               count_d = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACC: begin
            if (beat_s) begin
               ovf_d   = ovf_q | sum_s[ACC_W];
`ifdef ACC_SATURATE_EN
               acc_d   = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
               acc_d   = sum_s[ACC_W-1:0];
`endif
               count_d = count_q + CNT_W'(1);
               if (last_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ACC;
               end
            end else begin
               state_d = S_ACC;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == S_ACC);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.acc_out   = acc_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized plus directed bench for product_accumulator; two instances
// (ACC_W=8 and ACC_W=5, LEN=4) share stimulus and are checked against a sum model.
module tb_product_accumulator;
   localparam int LEN = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] prod;
   logic       in_valid;
   logic       out_ready;

   int n_checks;
   int n_err;

   // Model: phase 0=idle 1=accumulating 2=holding result; true unbounded sum
   int m_phase;
   int m_sum;
   int m_beats;

   product_accumulator_if #(.ACC_W(8)) bus8 ();
   product_accumulator_if #(.ACC_W(5)) bus5 ();

   assign bus8.start = start;     assign bus5.start = start;
   assign bus8.p3 = prod[3];      assign bus5.p3 = prod[3];
   assign bus8.p2 = prod[2];      assign bus5.p2 = prod[2];
   assign bus8.p1 = prod[1];      assign bus5.p1 = prod[1];
   assign bus8.p0 = prod[0];      assign bus5.p0 = prod[0];
   assign bus8.in_valid = in_valid;   assign bus5.in_valid = in_valid;
   assign bus8.out_ready = out_ready; assign bus5.out_ready = out_ready;

   product_accumulator #(.ACC_W(8), .LEN(LEN)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   product_accumulator #(.ACC_W(5), .LEN(LEN)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_acc(int s, int w);
      int lim;
      lim = 1 << w;
`ifdef ACC_SATURATE_EN
      return (s >= lim) ? lim - 1 : s;
`else
      return s % lim;
`endif
   endfunction

   task automatic chk(string name, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_sum   = 0;
         m_beats = 0;
      end else begin
         case (m_phase)
            0: if (start) begin m_phase = 1; m_sum = 0; m_beats = 0; end
            1: if (in_valid) begin
                  m_sum   = m_sum + int'(prod);
                  m_beats = m_beats + 1;
                  if (m_beats == LEN) m_phase = 2;
               end
            2: if (out_ready) m_phase = 0;
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready8",  int'(bus8.in_ready),  int'(m_phase == 1));
      chk("out_valid8", int'(bus8.out_valid), int'(m_phase == 2));
      chk("busy8",      int'(bus8.busy),      int'(m_phase != 0));
      chk("acc8",       int'(bus8.acc_out),   exp_acc(m_sum, 8));
      chk("ovf8",       int'(bus8.overflow),  int'(m_sum >= 256));
      chk("in_ready5",  int'(bus5.in_ready),  int'(m_phase == 1));
      chk("out_valid5", int'(bus5.out_valid), int'(m_phase == 2));
      chk("busy5",      int'(bus5.busy),      int'(m_phase != 0));
      chk("acc5",       int'(bus5.acc_out),   exp_acc(m_sum, 5));
      chk("ovf5",       int'(bus5.overflow),  int'(m_sum >= 32));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(int p, int gap);
      in_valid = 1'b0;
      repeat (gap) tick();
      prod     = 4'(p);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic pin_zero(string tag);
      chk({tag, "_acc8"},  int'(bus8.acc_out),   0);
      chk({tag, "_ovf5"},  int'(bus5.overflow),  0);
      chk({tag, "_valid"}, int'(bus8.out_valid), 0);
      chk({tag, "_ready"}, int'(bus8.in_ready),  0);
      chk({tag, "_busy"},  int'(bus8.busy),      0);
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      prod      = 4'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      pin_zero("reset");
      rst_n = 1'b1;
      tick();

      // Basic sum
      do_start();
      chk("t1_in_ready", int'(bus8.in_ready), 1);
      beat(9, 0); beat(6, 0); beat(4, 0); beat(1, 0);
      chk("t1_valid", int'(bus8.out_valid), 1);
      chk("t1_acc8",  int'(bus8.acc_out), 20);
      chk("t1_ovf8",  int'(bus8.overflow), 0);
      release_result();
      chk("t1_idle_valid", int'(bus8.out_valid), 0);
      chk("t1_idle_acc8",  int'(bus8.acc_out), 20);

      // Gaps, backpressure and 5-bit overflow
      do_start();
      beat(9, 0); beat(9, 3); beat(9, 3); beat(9, 3);
      for (int i = 0; i < 5; i++) begin
         chk("t2_acc8",  int'(bus8.acc_out), 36);
         chk("t2_valid", int'(bus8.out_valid), 1);
         chk("t2_ready", int'(bus8.in_ready), 0);
         tick();
      end
`ifdef ACC_SATURATE_EN
      chk("t2_acc5", int'(bus5.acc_out), 31);
`else
      chk("t2_acc5", int'(bus5.acc_out), 4);
`endif
      chk("t2_ovf5", int'(bus5.overflow), 1);
      release_result();

      // Start ignored while busy
      do_start();
      beat(2, 0); beat(3, 0);
      do_start();
      beat(0, 0); beat(1, 0);
      chk("t3_valid", int'(bus8.out_valid), 1);
      chk("t3_acc8",  int'(bus8.acc_out), 6);
      do_start();
      chk("t3_done_hold", int'(bus8.out_valid), 1);
      release_result();

      // Asynchronous reset mid-accumulation
      do_start();
      beat(1, 0); beat(1, 0);
      rst_n = 1'b0;
      #1;
      pin_zero("t4_rst");
      tick();
      rst_n = 1'b1;
      tick();
      do_start();
      beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0);
      chk("t4_acc8", int'(bus8.acc_out), 4);
      release_result();

      // Back-to-back, previous overflow cleared
      do_start();
      beat(15, 0); beat(15, 0); beat(15, 0); beat(15, 0);
      chk("t5_ovf5_set", int'(bus5.overflow), 1);
      release_result();
      do_start();
      chk("t5_ovf5_clr", int'(bus5.overflow), 0);
      beat(0, 0); beat(0, 0); beat(0, 0); beat(0, 0);
      chk("t5_acc8", int'(bus8.acc_out), 0);
      chk("t5_ovf5", int'(bus5.overflow), 0);
      release_result();

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         start     = ($urandom_range(0, 5) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         prod      = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) == 0);
         tick();
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator directly downstream of the 2-bit combinational multiplier. It consumes the multiplier's 4-bit product, one sample per accepted handshake, and sums LEN consecutive products into a dot-product result. It holds the result behind a valid/ready handshake until the consumer takes it. An overflow flag reports results that exceeded ACC_W bits.

## Interface
- ACC_W, 8, accumulator and result width in bits; legal range is ACC_W >= 4.
- LEN, 4, number of products summed per result; legal range is LEN >= 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a new accumulation; honoured only in IDLE.
- p3, p2, p1, p0  in  1 each  multiplier product bits, MSB first; form prod = {p3,p2,p1,p0}.
- in_valid  in  1  prod is valid this cycle.
- in_ready  out  1  block accepts prod this cycle.
- acc_out  out  ACC_W  accumulated result; stable while out_valid=1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- overflow  out  1  sticky per result; set when the true sum does not fit in ACC_W bits.
- busy  out  1  block is in ACC or DONE.

## Operation
- States:
  - IDLE: in_ready=0, out_valid=0, busy=0.
  - ACC: in_ready=1, busy=1.
  - DONE: out_valid=1, busy=1, in_ready=0.
- IDLE -> ACC on start=1.
  - Same edge: acc cleared to 0, count cleared to 0, overflow cleared to 0.
- In ACC, a beat is accepted when in_valid && in_ready.
  - acc <= acc + zero-extend(prod) to ACC_W bits.
  - count increments by 1.
- Cycles with in_valid=0 leave acc and count unchanged. Gaps are unlimited.
- ACC -> DONE on the edge that accepts beat number LEN (count == LEN-1 at acceptance).
- DONE -> IDLE on out_ready=1.
  - acc_out retains its value in IDLE until the next start.
- start outside IDLE is ignored. It has no effect on acc, count, or state.
- Arithmetic:
  - Sum computed at ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets overflow.
  - Once set, overflow stays 1 until the next start.
  - Without saturation, acc wraps modulo 2^ACC_W.
- count width is clog2(LEN+1). It never exceeds LEN-1 in ACC.
- A start pulse on the same edge as the DONE -> IDLE transition is not honoured. start must arrive while the state is IDLE.

## Timing
- Reset (asynchronous, any time including mid-accumulation):
  - State -> IDLE.
  - acc_out = 0, out_valid = 0, in_ready = 0, overflow = 0, busy = 0, count = 0.
- start sampled at edge T: in_ready=1 from cycle T+1.
- Product accepted at edge T is reflected in acc_out after T.
- The last beat accepted at edge T gives out_valid=1, final acc_out, and final overflow all in cycle T+1. Latency is 1 cycle.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Minimum cycles per result: 1 (start) + LEN (beats) + 1 (DONE with out_ready=1).

## Configuration
- ACC_SATURATE_EN:
  - Defined: on overflow, acc is clamped to 2^ACC_W-1 and stays there for the remaining beats; overflow is still set.
  - Undefined: acc wraps modulo 2^ACC_W and overflow is set.
- No other behaviour differs between the two builds.

## Test plan
- Basic sum: ACC_W=8, LEN=4. start, then prods 9,6,4,1 on consecutive cycles -> acc_out=20, overflow=0, out_valid=1 one cycle after the 4th beat. out_ready=1 -> IDLE.
- Gaps and backpressure: ACC_W=8, LEN=4. prods 9,9,9,9 with in_valid low for 3 cycles between beats, and out_ready held 0 for 5 cycles -> acc_out=36 held stable with out_valid=1 for all 5 cycles. in_ready=0 throughout DONE.
- Overflow: ACC_W=5, LEN=4, prods 9,9,9,9:
  - Without the macro -> acc_out=4, overflow=1.
  - With ACC_SATURATE_EN -> acc_out=31, overflow=1.
- Start ignored while busy: start pulse in ACC after 2 beats, prods 2,3,0,1 -> acc_out=6. count is not reset.
- Reset mid-operation: assert rst_n=0 between clock edges after 2 beats -> all outputs 0 immediately. A following start plus prods 1,1,1,1 -> acc_out=4.
- Back-to-back results: out_ready=1 in DONE, start in the next (IDLE) cycle, prods 0,0,0,0 -> acc_out=0 and overflow=0, with the previous result's overflow flag cleared.
